instr_encoder: RTL and testbench

//  Builds RV32I instruction words from decoded fields (fmt, opcode, rd, rs1, rs2, funct3, funct7, imm).
//  It is the inverse of the core's immediate extraction: it scatters a 32-bit immediate into the
//  I/S/B/U/J bit positions.
//  It also expands the LI pseudo-op into LUI+ADDI.

---
 rtl/rv32_pkg.sv | 40 ++++
 rtl/instr_encoder_imm_pack.sv | 45 ++++
 rtl/instr_encoder.sv | 116 +++++++++++
 tb/tb_instr_encoder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants: opcodes, instruction-format codes,
// immediate range limits and the encoder FSM state type.
package rv32_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_LI  = 3'd6,
        FMT_ILL = 3'd7
    } fmt_e;

    // Signed byte-offset limits; B and J additionally require an even offset.
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -(1 << 20);
    localparam int IMM_J_MAX = (1 << 20) - 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_LUI   = 2'd2
    } state_e;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Scatters a 32-bit immediate into its I/S/B/U/J instruction bit positions
// and flags immediates the chosen format cannot represent.
module imm_pack
    import rv32_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [31:0] imm,
    output logic [31:0] bits,
    output logic        err
);

    logic signed [31:0] simm;
    assign simm = $signed(imm);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        bits = '0;
        err  = 1'b0;
        unique case (fmt)
            FMT_I: begin
                bits = {imm[11:0], 20'b0};
                err  = (simm < IMM12_MIN) || (simm > IMM12_MAX);
            end
            FMT_S: begin
                bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                err  = (simm < IMM12_MIN) || (simm > IMM12_MAX);
            end
            FMT_B: begin
                bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                err  = (simm < IMM_B_MIN) || (simm > IMM_B_MAX) || imm[0];
            end
            FMT_U: begin
                bits = {imm[31:12], 12'b0};
                err  = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                err  = (simm < IMM_J_MIN) || (simm > IMM_J_MAX) || imm[0];
            end
            FMT_ILL: err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with LI -> LUI+ADDI expansion, behind a
// registered valid/ready stream (1-cycle latency, 1 word/cycle).
module instr_encoder
    import rv32_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int OP_LEN = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [OP_LEN-1:0] in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [XLEN-1:0]   in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_instr,
    output logic              out_err
);

    fmt_e            fmt;
    state_e          state_q, state_d;
    logic [31:0]     imm_bits;
    logic            imm_err;
    logic [31:0]     first_word, addi_word, lui_word, li_sum, pending_q;
    logic [19:0]     li_hi;
    logic [11:0]     li_lo;
    logic            first_err, li_two, accept;

    assign fmt = fmt_e'(in_fmt);

    imm_pack u_imm_pack (
        .fmt  (fmt),
        .imm  (in_imm),
        .bits (imm_bits),
        .err  (imm_err)
    );

    // Word that is registered on accept; for a two-word LI this is the LUI.
    always_comb begin
        li_sum     = in_imm + 32'h800;
        li_hi      = li_sum[31:12];
        li_lo      = in_imm[11:0];
        lui_word   = {li_hi, in_rd, OP_LUI};
        addi_word  = {li_lo, in_rd, 3'b000, in_rd, OP_IMM};
        li_two     = 1'b0;
        first_err  = imm_err;
        first_word = '0;
        unique case (fmt)
            FMT_R:        first_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I:        first_word = imm_bits | {12'b0, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S, FMT_B: first_word = imm_bits | {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, in_opcode};
            FMT_U, FMT_J: first_word = imm_bits | {20'b0, in_rd, in_opcode};
            FMT_LI: begin
                if (li_hi == 20'd0) begin
                    first_word = {li_lo, 5'd0, 3'b000, in_rd, OP_IMM};
                end else begin
                    first_word = lui_word;
                    li_two     = (li_lo != 12'd0);
                end
            end
            default:      first_word = '0;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (accept) state_d = li_two ? ST_LUI : ST_ONE;
            ST_ONE: begin
                if (accept)         state_d = li_two ? ST_LUI : ST_ONE;
                else if (out_ready) state_d = ST_EMPTY;
            end
            ST_LUI:   if (out_ready) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_EMPTY) || ((state_q == ST_ONE) && out_ready);
        out_valid = (state_q != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_instr <= first_word;
            out_err   <= first_err;
        end else if ((state_q == ST_LUI) && out_ready) begin
            out_instr <= pending_q;
            out_err   <= 1'b0;
        end
    end

    // NOTE: pending_q is data only and left unreset; it is read solely in ST_LUI, which reset leaves.
    always_ff @(posedge clk) begin
        if (accept && li_two) pending_q <= addi_word;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written
// LI / backpressure / reset sequences, then randomized traffic vs a reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_word;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm);
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1;
        in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    // Reference model: pushes the word(s) an accepted input must produce.
    task automatic model_push(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
        int          s;
        logic [31:0] w, lo, hi, regs;
        logic        e;
        s    = $signed(imm);
        e    = 1'b0;
        w    = 0;
        regs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (fmt)
            3'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7);
            3'd1: begin
                w = ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7);
                e = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs | ((imm & 32'h1F) << 7);
                e = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) | regs
                  | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
                e = (s < -4096) || (s > 4094) || ((imm & 1) != 0);
            end
            3'd4: begin
                w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
                e = (imm & 32'hFFF) != 0;
            end
            3'd5: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
                  | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'(op);
                e = (s < -(1 << 20)) || (s > (1 << 20) - 2) || ((imm & 1) != 0);
            end
            3'd6: begin
                lo = imm & 32'hFFF;
                hi = (imm + 32'h800) >> 12;
                if (hi == 0) begin
                    w = (lo << 20) | (32'(rd) << 7) | 32'h13;
                end else begin
                    w = (hi << 12) | (32'(rd) << 7) | 32'h37;
                    if (lo != 0) begin
                        exp_q.push_back('{w, 1'b0});
                        w = (lo << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
                    end
                end
            end
            default: begin
                w = 0;
                e = 1'b1;
            end
        endcase
        exp_q.push_back('{w, e});
    endtask

    // Monitor for the randomized phase: samples mid-cycle, after the negedge drive.
    initial begin
        logic        hold_prev;
        logic [31:0] prev_instr;
        logic        prev_err;
        exp_t        e;
        hold_prev = 1'b0;
        prev_instr = '0;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                hold_prev = 1'b0;
                continue;
            end
            if (!rst_n) begin
                exp_q.delete();
                hold_prev = 1'b0;
                continue;
            end
            check("rand_out_valid", out_valid, exp_q.size() > 0);
            check("rand_in_ready", in_ready,
                  (exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready));
            if (hold_prev) begin
                check("hold_instr", out_instr, prev_instr);
                check("hold_err", out_err, prev_err);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rand_unexpected_word: got %h expected no word", out_instr);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_instr", out_instr, e.word);
                    check("rand_err", out_err, e.err);
                end
            end
            hold_prev  = out_valid && !out_ready;
            prev_instr = out_instr;
            prev_err   = out_err;
            if (in_valid && in_ready)
                model_push(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
        end
    end

    vec_t vecs[15];
    int   bounds[17];

    initial begin
        vecs[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
        vecs[1]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd13,       32'h00000663, 1'b1};
        vecs[2]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFF000, 32'h80208063, 1'b0};
        vecs[3]  = '{3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000007FF, 32'h7FF00293, 1'b0};
        vecs[4]  = '{3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, 32'h000012B7, 1'b0};
        vecs[5]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        32'h002081B3, 1'b0};
        vecs[6]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFC, 32'hFE20AE23, 1'b0};
        vecs[7]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h80000093, 1'b1};
        vecs[8]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000093, 1'b0};
        vecs[9]  = '{3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h123450B7, 1'b1};
        vecs[10] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0};
        vecs[11] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 32'h800000EF, 1'b1};
        vecs[12] = '{3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'd5, 32'd5,        32'h00000000, 1'b1};
        vecs[13] = '{3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,        32'h00000293, 1'b0};
        vecs[14] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,     32'h7E000FE3, 1'b0};
        bounds = '{-4097, -4096, -2049, -2048, 2047, 2048, 4094, 4095, 4096, 1 << 20, (1 << 20) - 2,
                   -(1 << 20), -(1 << 20) - 2, 0, 32'h7FF, 32'h800, 32'hFFFFF800};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_in(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_instr", out_instr, 32'h0);
        check("reset_out_err", out_err, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);

        // Directed single-word table.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
            set_in(vecs[i].fmt, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].f3, vecs[i].f7, vecs[i].imm);
            #1;
            check($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
            check($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_word);
            check($sformatf("vec%0d_err", i), out_err, vecs[i].exp_err);
        end
        @(negedge clk);
        #1;
        check("idle_out_valid", out_valid, 1'b0);

        // LI expanding to LUI + ADDI, with an I word waiting behind it.
        @(negedge clk);
        in_valid = 1'b1;
        set_in(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678);
        @(negedge clk);
        set_in(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        #1;
        check("li_lui_word", out_instr, 32'h123452B7);
        check("li_lui_in_ready", in_ready, 1'b0);
        @(negedge clk);
        #1;
        check("li_addi_word", out_instr, 32'h67828293);
        check("li_addi_err", out_err, 1'b0);
        check("li_addi_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("li_next_word", out_instr, 32'hFFF00093);
        @(negedge clk);

        // Backpressure: two I words, consumer stalls for 3 cycles.
        out_ready = 1'b0; in_valid = 1'b1;
        set_in(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk);
        set_in(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d_instr", c), out_instr, 32'h00100093);
            check($sformatf("stall%0d_in_ready", c), in_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("stall_release_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("stall_second_word", out_instr, 32'h00200093);
        check("stall_second_valid", out_valid, 1'b1);
        @(negedge clk);
        #1;
        check("stall_drained", out_valid, 1'b0);

        // Reset while the LUI word is held: pending ADDI must never appear.
        out_ready = 1'b0; in_valid = 1'b1;
        set_in(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678);
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        #1;
        check("rst_lui_held", out_instr, 32'h123452B7);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        check("rst_lui_out_valid", out_valid, 1'b0);
        check("rst_lui_in_ready", in_ready, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst_no_addi%0d", c), out_valid, 1'b0);
        end

        // Randomized traffic checked by the monitor against the model.
        mon_en = 1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_fmt    = 3'($urandom_range(0, 7));
            in_opcode = 7'($urandom);
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_funct3 = 3'($urandom);
            in_funct7 = 7'($urandom);
            case ($urandom_range(0, 3))
                0: in_imm = $urandom;
                1: in_imm = 32'($signed($urandom_range(0, 10000)) - 5000);
                2: in_imm = bounds[$urandom_range(0, 16)];
                default: in_imm = $urandom & 32'hFFFFF000;
            endcase
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #3;
        check("drain_queue_empty", exp_q.size(), 0);
        mon_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
